// File: rtl/cic_decimator.sv
// N-stage CIC decimator with runtime decimation ratio and load/flush strobe.
// Define CIC_ROUND_EN for round-half-up with positive saturation instead of plain truncation.
module cic_decimator #(
  parameter int unsigned N        = 3,
  parameter int unsigned M        = 1,
  parameter int unsigned R_MAX    = 8,
  parameter int unsigned IN_BITS  = 16,
  parameter int unsigned OUT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_BITS-1:0]         stream_in,
  input  logic                       valid,
  input  logic [$clog2(R_MAX+1)-1:0] rate,
  input  logic                       rate_ld,
  output logic [OUT_BITS-1:0]        stream_out,
  output logic                       ready
);

  localparam int unsigned AccBits = IN_BITS + N * $clog2(R_MAX * M);
  localparam int unsigned RateW   = $clog2(R_MAX + 1);
  localparam int unsigned Shift   = AccBits - OUT_BITS;

  logic [AccBits-1:0] acc_q [N];
  logic [AccBits-1:0] acc_d [N];
  logic [AccBits-1:0] dly_q [N][M];
  logic [AccBits-1:0] comb  [N+1];
  logic [AccBits-1:0] ci_q;
  logic [RateW-1:0]   cnt_q;
  logic [RateW-1:0]   rate_q;
  logic [RateW-1:0]   rate_new;
  logic               pend_q;
  logic               strobe;
  logic [OUT_BITS-1:0] scaled;

  // Integrator chain: every stage sees the freshly updated value of the previous one.
  always_comb begin
    acc_d[0] = acc_q[0] + AccBits'($signed(stream_in));
    for (int k = 1; k < N; k++) begin
      acc_d[k] = acc_q[k] + acc_d[k-1];
    end
  end

  always_comb begin
    comb[0] = ci_q;
    for (int k = 0; k < N; k++) begin
      comb[k+1] = comb[k] - dly_q[k][M-1];
    end
  end

  assign strobe = valid && (cnt_q == rate_q - 1'b1);

  always_comb begin
    if (rate == '0 || rate > RateW'(R_MAX)) begin
      rate_new = RateW'(R_MAX);
    end else begin
      rate_new = rate;
    end
  end

`ifdef CIC_ROUND_EN
  localparam logic [AccBits:0] Half = ((AccBits+1)'(1) << Shift) >> 1;
  logic [AccBits:0] rnd_sum;

  always_comb begin
    rnd_sum = {comb[N][AccBits-1], comb[N]} + Half;
    // Adding a positive constant can only overflow upward.
    if (rnd_sum[AccBits] != rnd_sum[AccBits-1]) begin
      scaled = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else begin
      scaled = OUT_BITS'(rnd_sum >> Shift);
    end
  end
`else
  always_comb begin
    scaled = OUT_BITS'($signed(comb[N]) >>> Shift);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
        for (int j = 0; j < M; j++) dly_q[k][j] <= '0;
      end
      ci_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rate_q     <= RateW'(R_MAX);
      stream_out <= '0;
      ready      <= 1'b0;
    end else if (rate_ld) begin
      // Flush: a pending comb update is dropped along with the sample on this edge.
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
        for (int j = 0; j < M; j++) dly_q[k][j] <= '0;
      end
      ci_q   <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      rate_q <= rate_new;
      ready  <= 1'b0;
    end else begin
      ready  <= pend_q;
      pend_q <= strobe;
      if (pend_q) begin
        stream_out <= scaled;
        for (int k = 0; k < N; k++) begin
          dly_q[k][0] <= comb[k];
          for (int j = 1; j < M; j++) dly_q[k][j] <= dly_q[k][j-1];
        end
      end
      if (valid) begin
        for (int k = 0; k < N; k++) acc_q[k] <= acc_d[k];
        cnt_q <= strobe ? '0 : cnt_q + 1'b1;
        if (strobe) ci_q <= acc_d[N-1];
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator (N=3, M=1, R_MAX=8, 16-bit in/out).
module tb_cic_decimator;

  typedef struct {
    logic signed [15:0] val;
    int                 edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] stream_in = '0;
  logic        valid = 1'b0;
  logic [3:0]  rate = '0;
  logic        rate_ld = 1'b0;
  logic [15:0] stream_out;
  logic        ready;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   model_cnt = 0;
  int   model_rate = 8;
  int   out_idx = 0;
  int   seq [3];
  logic last_strobe = 1'b0;

  cic_decimator #(
    .N(3), .M(1), .R_MAX(8), .IN_BITS(16), .OUT_BITS(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stream_in (stream_in),
    .valid     (valid),
    .rate      (rate),
    .rate_ld   (rate_ld),
    .stream_out(stream_out),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic set_seq(input int a, input int b, input int c);
    seq[0] = a;
    seq[1] = b;
    seq[2] = c;
  endtask

  // Applies one cycle of inputs; expected outputs appear two edges after a strobe sample.
  task automatic drive(input logic v, input int x, input logic ld, input int r, input logic rs);
    exp_t e;
    rst = rs;
    valid = v;
    stream_in = 16'(x);
    rate_ld = ld;
    rate = 4'(r);
    if (rs) begin
      q.delete();
      model_cnt = 0;
      model_rate = 8;
      out_idx = 0;
      last_strobe = 1'b0;
    end else if (ld) begin
      if (last_strobe && q.size() > 0) void'(q.pop_back());
      model_cnt = 0;
      model_rate = (r == 0 || r > 8) ? 8 : r;
      out_idx = 0;
      last_strobe = 1'b0;
    end else begin
      last_strobe = 1'b0;
      if (v) begin
        model_cnt++;
        if (model_cnt == model_rate) begin
          model_cnt = 0;
          e.val = 16'(seq[(out_idx < 2) ? out_idx : 2]);
          e.edge_no = edge_n + 2;
          q.push_back(e);
          out_idx++;
          last_strobe = 1'b1;
        end
      end
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: edge %0d value %0d, expected no output", edge_n,
                 $signed(stream_out));
      end else begin
        exp_t e;
        e = q.pop_front();
        if (stream_out !== e.val || edge_n != e.edge_no) begin
          errors++;
          $display("FAIL output: got %0d at edge %0d, expected %0d at edge %0d",
                   $signed(stream_out), edge_n, e.val, e.edge_no);
        end
      end
    end else if (q.size() > 0 && q[0].edge_no <= edge_n) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_ready: no output at edge %0d, expected %0d", edge_n, e.val);
    end
  end

  initial begin
    set_seq(23, 89, 100);
    // Reset and idle.
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    drive(1'b1, 500, 1'b0, 0, 1'b1);
    check("reset_out", int'($signed(stream_out)), 0);
    check("reset_ready", int'(ready), 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b0, 0, 1'b0);
    check("idle_out", int'($signed(stream_out)), 0);
    check("idle_ready", int'(ready), 0);

    // DC +100 at reset ratio 8.
    for (int i = 0; i < 40; i++) drive(1'b1, 100, 1'b0, 0, 1'b0);

    // DC -100, long enough to wrap the integrators.
`ifdef CIC_ROUND_EN
    set_seq(-23, -89, -100);
`else
    set_seq(-24, -90, -100);
`endif
    drive(1'b1, 777, 1'b1, 8, 1'b0);
    for (int i = 0; i < 4200; i++) drive(1'b1, -100, 1'b0, 0, 1'b0);
    check("wrap_out", int'($signed(stream_out)), -100);

    // Ratio 4, then ratio 0 which falls back to 8.
`ifdef CIC_ROUND_EN
    set_seq(4, 12, 13);
`else
    set_seq(3, 11, 12);
`endif
    drive(1'b1, 100, 1'b1, 4, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 100, 1'b0, 0, 1'b0);
    set_seq(23, 89, 100);
    drive(1'b0, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 100, 1'b0, 0, 1'b0);

    // Flush one cycle after a strobe cancels the pending output.
    for (int i = 0; i < 20 && !last_strobe; i++) drive(1'b1, 100, 1'b0, 0, 1'b0);
    check("found_strobe", int'(last_strobe), 1);
    drive(1'b1, 100, 1'b1, 8, 1'b0);
    check("cancel_ready", int'(ready), 0);
    for (int i = 0; i < 40; i++) drive(1'b1, 100, 1'b0, 0, 1'b0);

    // Alternating valid: outputs every 16 cycles.
    drive(1'b0, 0, 1'b1, 8, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'(i % 2 == 0), 100, 1'b0, 0, 1'b0);
    check("toggle_out", int'($signed(stream_out)), 100);

    // Reset mid-stream, then confirm the ratio returns to 8.
    drive(1'b1, 100, 1'b0, 0, 1'b1);
    check("midrst_ready", int'(ready), 0);
    check("midrst_out", int'($signed(stream_out)), 0);
    for (int i = 0; i < 40; i++) drive(1'b1, 100, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0, 0, 1'b0);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
